// File: rtl/ps2_scancode_rx_pkg.sv
// Shared PS/2 receiver types: prefix codes, frame FSM states and the event word.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Event stream from the PS/2 receiver toward the game controller.
interface ps2_scancode_rx_if #(
  parameter int FIFO_DEPTH = 8
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_brk;
  logic          ev_valid;
  logic          ev_ready;
  logic [CW-1:0] ev_count;

  modport master (
    output ev_code, ev_ext, ev_brk, ev_valid, ev_count,
    input  ev_ready
  );

  modport slave (
    input  ev_code, ev_ext, ev_brk, ev_valid, ev_count,
    output ev_ready
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter; the filtered level
// follows the line only after FILT_CYCLES consecutive differing samples.
module ps2_line_filter #(
  parameter int FILT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic filt
);

  logic [1:0] sync;
  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which keeps the synchroniser chain a true two-stage delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == 8'(FILT_CYCLES - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frame FSM with parity/stop/timeout checking,
// E0/F0 prefix decoder, optional repeat suppression and a fall-through event FIFO.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int FILT_CYCLES     = 8,
  parameter int TIMEOUT_US      = 2000,
  parameter int FIFO_DEPTH      = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     kclk,
  input  logic                     kdata,
  ps2_scancode_rx_if.master        ev,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = AW + 1;
  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  logic kclk_f, kdata_f;

  ps2_line_filter #(.FILT_CYCLES(FILT_CYCLES)) u_kclk_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .line (kclk),
    .filt (kclk_f)
  );

  ps2_line_filter #(.FILT_CYCLES(FILT_CYCLES)) u_kdata_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .line (kdata),
    .filt (kdata_f)
  );

  // ---------------- frame FSM ----------------
  frame_state_t  state;
  logic          kclk_q, fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          byte_vld;
  logic [TW-1:0] tcnt;
  logic          parity_ok;

  assign parity_ok = ^{shreg, par_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      kclk_q     <= 1'b1;
      fall       <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      byte_vld   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      tcnt       <= '0;
    end else begin
      kclk_q     <= kclk_f;
      fall       <= kclk_q & ~kclk_f;
      byte_vld   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;

      // A stalled frame is abandoned; the partial byte is never decoded.
      if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYC)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!kdata_f) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {kdata_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= kdata_f;
            state   <= STOP;
          end
          STOP: begin
            if (kdata_f) begin
              if (parity_ok) byte_vld   <= 1'b1;
              else           parity_err <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              if (!parity_ok) parity_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------- prefix decoder / repeat filter ----------------
  logic       ext_pend, brk_pend;
  logic       last_vld;
  logic [8:0] last_make;
  logic       is_prefix, repeat_hit, push;
  ps2_event_t push_ev;

  assign is_prefix  = (shreg == PS2_EXT) || (shreg == PS2_BRK);
  assign repeat_hit = (SUPPRESS_REPEAT != 0) && !brk_pend && last_vld &&
                      (last_make == {ext_pend, shreg});
  assign push       = byte_vld && !is_prefix && !repeat_hit;
  assign push_ev    = '{ext: ext_pend, brk: brk_pend, code: shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      last_vld  <= 1'b0;
      last_make <= '0;
    end else if (byte_vld) begin
      if (shreg == PS2_EXT) begin
        ext_pend <= 1'b1;
      end else if (shreg == PS2_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        if (brk_pend) begin
          last_vld <= 1'b0;
        end else if (!repeat_hit) begin
          last_make <= {ext_pend, shreg};
          last_vld  <= 1'b1;
        end
      end
    end
  end

  // ---------------- event FIFO ----------------
  ps2_event_t    mem [FIFO_DEPTH];
  ps2_event_t    head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, not_empty, pop, wr_en;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = not_empty && ev.ev_ready;
  assign wr_en     = push && (!full || pop);

  // NOTE: the storage array carries no reset; only pointers and count do.
  // Outputs are gated by occupancy so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign ev.ev_valid = not_empty;
  assign ev.ev_count = count;
  assign ev.ev_code  = not_empty ? head.code : 8'h00;
  assign ev.ev_ext   = not_empty & head.ext;
  assign ev.ev_brk   = not_empty & head.brk;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed scenarios plus randomized
// byte streams compared against a queue-based event model.
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int FILT   = 4;
  localparam int TO_US  = 200;
  localparam int DEPTH  = 4;
  localparam int HALF   = 20;
  localparam int TO_CYC = CLK_HZ / 1_000_000 * TO_US;
  localparam int LAT    = 2 + FILT + 3;

  logic clk = 1'b0, rst_n = 1'b0, kclk = 1'b1, kdata = 1'b1;
  logic parity_err, frame_err, overflow;

  ps2_scancode_rx_if #(.FIFO_DEPTH(DEPTH)) ev_if ();

  ps2_scancode_rx #(
    .CLK_HZ(CLK_HZ), .FILT_CYCLES(FILT), .TIMEOUT_US(TO_US),
    .FIFO_DEPTH(DEPTH), .SUPPRESS_REPEAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata), .ev(ev_if),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int par_hi = 0, frm_hi = 0, ovf_hi = 0;

  // Cycles each pulse is high; one clean pulse adds exactly one.
  always @(negedge clk) begin
    if (parity_err === 1'b1) par_hi++;
    if (frame_err === 1'b1)  frm_hi++;
    if (overflow === 1'b1)   ovf_hi++;
  end

  // ---------------- reference model ----------------
  logic [9:0] q[$];
  bit         m_ext, m_brk, m_last_vld;
  logic [8:0] m_last;
  int         exp_ovf = 0;

  task automatic model_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_last_vld = 0; m_last = '0;
  endtask

  // Consumer is assumed stalled while bytes are being sent.
  task automatic model_byte(input logic [7:0] b);
    bit drop;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      drop = !m_brk && m_last_vld && (m_last == {m_ext, b});
      if (m_brk) m_last_vld = 0;
      else if (!drop) begin m_last = {m_ext, b}; m_last_vld = 1; end
      if (!drop) begin
        if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
        else exp_ovf++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, output int lat);
    logic [10:0] f;
    f   = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      kdata = f[i];
      repeat (HALF) @(negedge clk);
      kclk = 1'b0;
      for (int c = 1; c <= HALF; c++) begin
        @(negedge clk);
        if (i == 10 && lat == 0 && ev_if.ev_valid === 1'b1) lat = c;
      end
      kclk = 1'b1;
    end
    kdata = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    int lat;
    send_frame(b, 0, 0, 11, lat);
    model_byte(b);
  endtask

  task automatic read_event(output logic [9:0] ev, output bit got);
    got = 0;
    ev  = 'x;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (ev_if.ev_valid === 1'b1) begin
        ev  = {ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code};
        got = 1;
      end
    end
    ev_if.ev_ready = 1'b1;
    @(negedge clk);
    ev_if.ev_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ev: got %b want 0", {ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code});
    end
    n_tests++;
    if ({ev_if.ev_count, parity_err, frame_err, overflow} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_misc: got %b want 0", {ev_if.ev_count, parity_err, frame_err, overflow});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_plain_make();
    int lat; logic [9:0] got_ev, exp; bit got;
    send_frame(8'h1C, 0, 0, 11, lat);
    model_byte(8'h1C);
    n_tests++;
    if (lat !== LAT) begin n_fail++; $display("FAIL plain_latency: got %0d want %0d", lat, LAT); end
    while (q.size() > 0) begin
      exp = q.pop_front();
      read_event(got_ev, got);
      n_tests++;
      if (!got || got_ev !== exp) begin n_fail++; $display("FAIL plain_event: got %h want %h", got_ev, exp); end
    end
    n_tests++;
    if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL plain_empty: got %b want 0", ev_if.ev_valid); end
  endtask

  task automatic test_ext_break();
    logic [9:0] got_ev, exp; bit got;
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    n_tests++;
    if (ev_if.ev_count !== 3'd1) begin n_fail++; $display("FAIL extbrk_count: got %0d want 1", ev_if.ev_count); end
    while (q.size() > 0) begin
      exp = q.pop_front();
      read_event(got_ev, got);
      n_tests++;
      if (!got || got_ev !== exp) begin n_fail++; $display("FAIL extbrk_event: got %h want %h", got_ev, exp); end
    end
  endtask

  task automatic test_bad_parity();
    int lat, p0, f0; logic [9:0] got_ev, exp; bit got;
    p0 = par_hi; f0 = frm_hi;
    send_frame(8'h1C, 1, 0, 11, lat);
    n_tests++;
    if (par_hi - p0 !== 1 || frm_hi - f0 !== 0) begin
      n_fail++; $display("FAIL badpar_pulses: got par=%0d frm=%0d want 1 0", par_hi - p0, frm_hi - f0);
    end
    n_tests++;
    if (ev_if.ev_count !== 3'd0) begin n_fail++; $display("FAIL badpar_fifo: got %0d want 0", ev_if.ev_count); end
    send_good(8'h1B);
    while (q.size() > 0) begin
      exp = q.pop_front();
      read_event(got_ev, got);
      n_tests++;
      if (!got || got_ev !== exp) begin n_fail++; $display("FAIL badpar_event: got %h want %h", got_ev, exp); end
    end
  endtask

  task automatic test_timeout();
    int lat, p0, f0; logic [9:0] got_ev, exp; bit got;
    p0 = par_hi; f0 = frm_hi;
    send_frame(8'h5A, 0, 0, 5, lat);
    repeat (TO_CYC + 10) @(negedge clk);
    n_tests++;
    if (frm_hi - f0 !== 1 || par_hi - p0 !== 0) begin
      n_fail++; $display("FAIL timeout_pulses: got frm=%0d par=%0d want 1 0", frm_hi - f0, par_hi - p0);
    end
    n_tests++;
    if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_fifo: got %b want 0", ev_if.ev_valid); end
    send_good(8'h23);
    while (q.size() > 0) begin
      exp = q.pop_front();
      read_event(got_ev, got);
      n_tests++;
      if (!got || got_ev !== exp) begin n_fail++; $display("FAIL timeout_event: got %h want %h", got_ev, exp); end
    end
  endtask

  task automatic test_repeat_overflow();
    int o0; logic [9:0] got_ev, exp; bit got;
    logic [7:0] seq [4] = '{8'h1D, 8'h1E, 8'h1F, 8'h20};
    o0 = ovf_hi;
    repeat (3) send_good(8'h1C);
    n_tests++;
    if (ev_if.ev_count !== 3'd1) begin n_fail++; $display("FAIL repeat_count: got %0d want 1", ev_if.ev_count); end
    for (int i = 0; i < 4; i++) begin
      send_good(seq[i]);
      n_tests++;
      if (ovf_hi - o0 !== (i == 3 ? 1 : 0)) begin
        n_fail++; $display("FAIL overflow_pulse_%0d: got %0d want %0d", i, ovf_hi - o0, (i == 3 ? 1 : 0));
      end
    end
    n_tests++;
    if (ev_if.ev_count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d want 4", ev_if.ev_count); end
    while (q.size() > 0) begin
      exp = q.pop_front();
      read_event(got_ev, got);
      n_tests++;
      if (!got || got_ev !== exp) begin n_fail++; $display("FAIL overflow_order: got %h want %h", got_ev, exp); end
    end
    n_tests++;
    if (ev_if.ev_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_drained: got %b want 0", ev_if.ev_valid); end
  endtask

  task automatic test_reset_mid_frame();
    int lat; logic [9:0] got_ev, exp; bit got;
    send_good(8'h1C);
    send_good(8'hE0);
    send_frame(8'h3C, 0, 0, 6, lat);
    n_tests++;
    if (ev_if.ev_count !== 3'd1) begin n_fail++; $display("FAIL midrst_pre: got %0d want 1", ev_if.ev_count); end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ev_if.ev_valid, ev_if.ev_count, ev_if.ev_code, ev_if.ev_ext, ev_if.ev_brk,
         parity_err, frame_err, overflow} !== 17'd0) begin
      n_fail++; $display("FAIL midrst_outputs: valid=%b count=%0d code=%h not all 0",
                         ev_if.ev_valid, ev_if.ev_count, ev_if.ev_code);
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_good(8'h1C);
    send_good(8'h29);
    while (q.size() > 0) begin
      exp = q.pop_front();
      read_event(got_ev, got);
      n_tests++;
      if (!got || got_ev !== exp) begin n_fail++; $display("FAIL midrst_event: got %h want %h", got_ev, exp); end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h1C, 8'h1D, 8'h75, 8'h6B, 8'hE1, 8'hAA};
    logic [9:0] got_ev, exp; bit got;
    int lat, p0, f0, o0, e0, ep, ef, n, r;
    logic [7:0] b;
    for (int batch = 0; batch < 4; batch++) begin
      p0 = par_hi; f0 = frm_hi; o0 = ovf_hi; e0 = exp_ovf; ep = 0; ef = 0;
      n = $urandom_range(2, 7);
      for (int k = 0; k < n; k++) begin
        b = pool[$urandom_range(0, 7)];
        r = $urandom_range(0, 9);
        if (r == 0)      begin send_frame(b, 1, 0, 11, lat); ep++; end
        else if (r == 1) begin send_frame(b, 0, 1, 11, lat); ef++; end
        else             send_good(b);
      end
      n_tests++;
      if (par_hi - p0 !== ep || frm_hi - f0 !== ef || ovf_hi - o0 !== exp_ovf - e0) begin
        n_fail++;
        $display("FAIL rand_pulses_%0d: got par=%0d frm=%0d ovf=%0d want %0d %0d %0d", batch,
                 par_hi - p0, frm_hi - f0, ovf_hi - o0, ep, ef, exp_ovf - e0);
      end
      n_tests++;
      if (ev_if.ev_count !== 3'(q.size())) begin
        n_fail++; $display("FAIL rand_count_%0d: got %0d want %0d", batch, ev_if.ev_count, q.size());
      end
      while (q.size() > 0) begin
        exp = q.pop_front();
        read_event(got_ev, got);
        n_tests++;
        if (!got || got_ev !== exp) begin n_fail++; $display("FAIL rand_event_%0d: got %h want %h", batch, got_ev, exp); end
      end
    end
  endtask

  initial begin
    ev_if.ev_ready = 1'b0;
    model_reset();
    test_reset();
    test_plain_make();
    test_ext_break();
    test_bad_parity();
    test_timeout();
    test_repeat_overflow();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
